// File: rtl/median_engine_arbiter.sv
// Shares one pipelined median engine between two requesters. Jobs are granted round-robin under
// per-requester credit, tagged through a latency-matched pipeline, and returned via result FIFOs.
module median_engine_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int MED_LATENCY = 3,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    req0_valid,
  output logic                    req0_ready,
  input  logic [8*DATA_WIDTH-1:0] req0_data,
  input  logic [3:0]              req0_count,

  input  logic                    req1_valid,
  output logic                    req1_ready,
  input  logic [8*DATA_WIDTH-1:0] req1_data,
  input  logic [3:0]              req1_count,

  output logic                    med_valid_in,
  output logic [8*DATA_WIDTH-1:0] med_data,
  output logic [3:0]              med_count,
  input  logic                    med_valid_out,
  input  logic [DATA_WIDTH-1:0]   med_median,

  output logic                    res0_valid,
  input  logic                    res0_ready,
  output logic [DATA_WIDTH-1:0]   res0_median,

  output logic                    res1_valid,
  input  logic                    res1_ready,
  output logic [DATA_WIDTH-1:0]   res1_median,

  output logic                    cnt_err,
  output logic                    seq_err
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);

  // Combinational arbitration and capture signals
  logic [1:0]              w_req_valid;
  logic [1:0]              w_elig;
  logic [1:0]              w_cand;
  logic [1:0]              w_grant;
  logic [1:0]              w_res_ready;
  logic [1:0]              w_res_valid;
  logic [1:0]              w_pop;
  logic [1:0]              w_push;
  logic [1:0]              w_dec;
  logic                    w_fire;
  logic                    w_gid;
  logic                    w_seq_hit;
  logic                    w_bad_count;
  logic [8*DATA_WIDTH-1:0] w_sel_data;
  logic [3:0]              w_sel_count;

  // Per-requester FIFO and credit state
  logic [CW-1:0]           r_fifo_cnt [2];
  logic [CW-1:0]           r_inflight [2];
  logic [PW-1:0]           r_wr_ptr   [2];
  logic [PW-1:0]           r_rd_ptr   [2];
  logic [DATA_WIDTH-1:0]   r_mem      [2][FIFO_DEPTH];

  // Issue stage, tag pipeline and sticky flags
  logic                    r_rr_last;
  logic                    r_med_valid;
  logic                    r_issue_id;
  logic [8*DATA_WIDTH-1:0] r_med_data;
  logic [3:0]              r_med_count;
  logic [MED_LATENCY-1:0]  r_tag_v;
  logic [MED_LATENCY-1:0]  r_tag_id;
  logic                    r_cnt_err;
  logic                    r_seq_err;

  assign w_req_valid = {req1_valid, req0_valid};
  assign w_res_ready = {res1_ready, res0_ready};

  // Credit counts only registered state, so a pop returns its credit one cycle later.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      w_elig[i] = ({1'b0, r_fifo_cnt[i]} + {1'b0, r_inflight[i]}) < DEPTH_C;
    end
  end

  // NOTE: ready is masked during rst so no job can be accepted on a reset edge.
  assign w_cand = w_req_valid & w_elig & {2{~rst}};

  always_comb begin
    w_grant = w_cand;
    if (&w_cand) begin
      w_grant = r_rr_last ? 2'b01 : 2'b10;
    end
  end

  assign w_fire      = |w_grant;
  assign w_gid       = w_grant[1];
  assign w_sel_data  = w_gid ? req1_data  : req0_data;
  assign w_sel_count = w_gid ? req1_count : req0_count;
  assign w_bad_count = w_sel_count > 4'd8;

  assign req0_ready = w_grant[0];
  assign req1_ready = w_grant[1];

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_med_valid <= 1'b0;
      r_issue_id  <= 1'b0;
      r_med_data  <= '0;
      r_med_count <= '0;
      r_rr_last   <= 1'b1;
      r_cnt_err   <= 1'b0;
    end else begin
      r_med_valid <= w_fire;
      if (w_fire) begin
        r_issue_id  <= w_gid;
        r_med_data  <= w_sel_data;
        r_med_count <= w_bad_count ? 4'd0 : w_sel_count;
        r_rr_last   <= w_gid;
        if (w_bad_count) begin
          r_cnt_err <= 1'b1;
        end
      end
    end
  end

  // Stage 0 loads alongside the engine strobe; the last stage lines up with med_valid_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tag_v  <= '0;
      r_tag_id <= '0;
    end else begin
      r_tag_v[0]  <= r_med_valid;
      r_tag_id[0] <= r_issue_id;
      for (int s = 1; s < MED_LATENCY; s++) begin
        r_tag_v[s]  <= r_tag_v[s-1];
        r_tag_id[s] <= r_tag_id[s-1];
      end
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_push    = 2'b00;
    w_dec     = 2'b00;
    w_seq_hit = 1'b0;
    if (r_tag_v[MED_LATENCY-1]) begin
      w_dec = r_tag_id[MED_LATENCY-1] ? 2'b10 : 2'b01;
      if (med_valid_out) begin
        w_push = w_dec;
      end else begin
        w_seq_hit = 1'b1;
      end
    end else if (med_valid_out) begin
      w_seq_hit = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seq_err <= 1'b0;
    end else if (w_seq_hit) begin
      r_seq_err <= 1'b1;
    end
  end

  assign w_res_valid = {(r_fifo_cnt[1] != '0), (r_fifo_cnt[0] != '0)};
  assign w_pop       = w_res_valid & w_res_ready;

  // NOTE: result storage is reset so the head outputs read 0 after rst, not stale data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_cnt[i] <= '0;
        r_inflight[i] <= '0;
        r_wr_ptr[i]   <= '0;
        r_rd_ptr[i]   <= '0;
        for (int e = 0; e < FIFO_DEPTH; e++) begin
          r_mem[i][e] <= '0;
        end
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (w_push[i]) begin
          r_mem[i][r_wr_ptr[i]] <= med_median;
          r_wr_ptr[i]           <= r_wr_ptr[i] + 1'b1;
        end
        if (w_pop[i]) begin
          r_rd_ptr[i] <= r_rd_ptr[i] + 1'b1;
        end
        r_fifo_cnt[i] <= r_fifo_cnt[i] + CW'(w_push[i]) - CW'(w_pop[i]);
        r_inflight[i] <= r_inflight[i] + CW'(w_grant[i]) - CW'(w_dec[i]);
      end
    end
  end

  assign med_valid_in = r_med_valid;
  assign med_data     = r_med_data;
  assign med_count    = r_med_count;
  assign res0_valid   = w_res_valid[0];
  assign res1_valid   = w_res_valid[1];
  assign res0_median  = r_mem[0][r_rd_ptr[0]];
  assign res1_median  = r_mem[1][r_rd_ptr[1]];
  assign cnt_err      = r_cnt_err;
  assign seq_err      = r_seq_err;

  // The credit rule guarantees a full FIFO never sees a push without a matching pop.
  for (genvar g = 0; g < 2; g++) begin : g_ovf
    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(w_push[g] && !w_pop[g] && (r_fifo_cnt[g] == CW'(FIFO_DEPTH))));
  end

endmodule

// File: tb/tb_median_engine_arbiter.sv
// Bench for median_engine_arbiter: behavioural median engine, round-robin/credit reference
// model and per-requester result scoreboards driven by directed and random traffic.
module tb_median_engine_arbiter;

  localparam int DW    = 16;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;
  localparam int WW    = 8 * DW;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req0_valid = 1'b0;
  logic            req1_valid = 1'b0;
  logic [WW-1:0]   req0_data  = '0;
  logic [WW-1:0]   req1_data  = '0;
  logic [3:0]      req0_count = '0;
  logic [3:0]      req1_count = '0;
  logic            req0_ready, req1_ready;
  logic            med_valid_in;
  logic [WW-1:0]   med_data;
  logic [3:0]      med_count;
  logic            med_valid_out = 1'b0;
  logic [DW-1:0]   med_median    = '0;
  logic            res0_valid, res1_valid;
  logic            res0_ready = 1'b0;
  logic            res1_ready = 1'b0;
  logic [DW-1:0]   res0_median, res1_median;
  logic            cnt_err, seq_err;

  int              n_checks = 0;
  int              n_fail   = 0;
  logic [DW-1:0]   exp_q0[$];
  logic [DW-1:0]   exp_q1[$];
  logic            inject  = 1'b0;
  logic            tb_last = 1'b1;
  logic [LAT-1:0]  eng_v   = '0;
  logic [DW-1:0]   eng_m [LAT] = '{default: '0};

  always #5 clk = ~clk;

  median_engine_arbiter #(
    .DATA_WIDTH (DW),
    .MED_LATENCY(LAT),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_data    (req0_data),
    .req0_count   (req0_count),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_data    (req1_data),
    .req1_count   (req1_count),
    .med_valid_in (med_valid_in),
    .med_data     (med_data),
    .med_count    (med_count),
    .med_valid_out(med_valid_out),
    .med_median   (med_median),
    .res0_valid   (res0_valid),
    .res0_ready   (res0_ready),
    .res0_median  (res0_median),
    .res1_valid   (res1_valid),
    .res1_ready   (res1_ready),
    .res1_median  (res1_median),
    .cnt_err      (cnt_err),
    .seq_err      (seq_err)
  );

  task automatic check(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Median of the first n pixels; an even count averages the two middle values, invalid counts give 0.
  function automatic logic [DW-1:0] median_of(input logic [WW-1:0] d, input int n);
    int a[8];
    int t;
    if (n < 1 || n > 8) return '0;
    for (int k = 0; k < n; k++) a[k] = int'(d[k*DW +: DW]);
    for (int i = 1; i < n; i++) begin
      for (int j = i; j > 0 && a[j-1] > a[j]; j--) begin
        t = a[j]; a[j] = a[j-1]; a[j-1] = t;
      end
    end
    if (n % 2 == 1) return DW'(a[n/2]);
    return DW'((a[n/2-1] + a[n/2]) / 2);
  endfunction

  function automatic logic [WW-1:0] rand_pix();
    logic [WW-1:0] d;
    for (int k = 0; k < 8; k++) d[k*DW +: DW] = DW'($urandom);
    return d;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Engine model: samples the job strobe mid-cycle, answers LAT cycles after med_valid_in.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = LAT - 1; k > 0; k--) begin
        eng_v[k] = eng_v[k-1];
        eng_m[k] = eng_m[k-1];
      end
      eng_v[0] = med_valid_in;
      eng_m[0] = median_of(med_data, int'(med_count));
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      med_valid_out = eng_v[LAT-1] | inject;
      med_median    = eng_m[LAT-1];
    end
  end

  // Monitor: reference arbiter, scoreboard push on accepted jobs, pop/compare on delivered results.
  initial begin : monitor
    logic c0, c1, e0, e1;
    forever begin
      @(negedge clk);
      if (rst) begin
        check("ready0_in_reset", WW'(req0_ready), WW'(1'b0));
        check("ready1_in_reset", WW'(req1_ready), WW'(1'b0));
        tb_last = 1'b1;
      end else begin
        c0 = req0_valid && (exp_q0.size() < DEPTH);
        c1 = req1_valid && (exp_q1.size() < DEPTH);
        if (c0 && c1) begin
          e0 = tb_last;
          e1 = !tb_last;
        end else begin
          e0 = c0;
          e1 = c1;
        end
        check("grant0", WW'(req0_ready), WW'(e0));
        check("grant1", WW'(req1_ready), WW'(e1));
        if (req0_valid && req0_ready) begin
          exp_q0.push_back(median_of(req0_data, int'(req0_count)));
          tb_last = 1'b0;
        end
        if (req1_valid && req1_ready) begin
          exp_q1.push_back(median_of(req1_data, int'(req1_count)));
          tb_last = 1'b1;
        end
        if (res0_valid && res0_ready) begin
          check("res0_expected_pending", WW'(exp_q0.size() != 0), WW'(1'b1));
          if (exp_q0.size() != 0) check("res0_median", WW'(res0_median), WW'(exp_q0.pop_front()));
        end
        if (res1_valid && res1_ready) begin
          check("res1_expected_pending", WW'(exp_q1.size() != 0), WW'(1'b1));
          if (exp_q1.size() != 0) check("res1_median", WW'(res1_median), WW'(exp_q1.pop_front()));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    exp_q0.delete();
    exp_q1.delete();
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_med_valid_in"}, WW'(med_valid_in), WW'(1'b0));
    check({tag, "_med_data"},     med_data,          WW'(0));
    check({tag, "_med_count"},    WW'(med_count),    WW'(0));
    check({tag, "_res0_valid"},   WW'(res0_valid),   WW'(1'b0));
    check({tag, "_res1_valid"},   WW'(res1_valid),   WW'(1'b0));
    check({tag, "_res0_median"},  WW'(res0_median),  WW'(0));
    check({tag, "_res1_median"},  WW'(res1_median),  WW'(0));
    check({tag, "_cnt_err"},      WW'(cnt_err),      WW'(1'b0));
    check({tag, "_seq_err"},      WW'(seq_err),      WW'(1'b0));
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [WW-1:0] p1_data;
    int g0, g1, lat;
    logic found;

    // Reset state
    step();
    step();
    @(negedge clk);
    check_all_zero("reset");
    step();
    rst = 1'b0;

    // Single job on req0, pixels 10..80 -> median 45, result visible 5 cycles after handshake
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    for (int k = 0; k < 8; k++) p1_data[k*DW +: DW] = DW'(10 * (k + 1));
    req0_data  = p1_data;
    req0_count = 4'd8;
    req0_valid = 1'b1;
    @(negedge clk);
    check("p1_ready0", WW'(req0_ready), WW'(1'b1));
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("p1_med_valid_in", WW'(med_valid_in), WW'(1'b1));
    check("p1_med_count", WW'(med_count), WW'(8));
    check("p1_med_data", med_data, p1_data);
    step();
    step();
    step();
    @(negedge clk);
    check("p1_res0_early", WW'(res0_valid), WW'(1'b0));
    step();
    @(negedge clk);
    check("p1_res0_valid", WW'(res0_valid), WW'(1'b1));
    check("p1_res0_median", WW'(res0_median), WW'(45));
    check("p1_res1_valid", WW'(res1_valid), WW'(1'b0));
    step();

    // Both requesters valid for 8 cycles after reset: grants alternate starting with req0
    do_reset();
    g0 = 0;
    g1 = 0;
    for (int i = 0; i < 8; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      req0_data  = rand_pix();
      req1_data  = rand_pix();
      req0_count = 4'($urandom_range(1, 8));
      req1_count = 4'($urandom_range(1, 8));
      @(negedge clk);
      check("p2_alt0", WW'(req0_ready), WW'(i % 2 == 0));
      check("p2_alt1", WW'(req1_ready), WW'(i % 2 == 1));
      if (req0_ready) g0++;
      if (req1_ready) g1++;
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (12) step();
    @(negedge clk);
    check("p2_jobs0", WW'(g0), WW'(4));
    check("p2_jobs1", WW'(g1), WW'(4));
    check("p2_drained0", WW'(exp_q0.size()), WW'(0));
    check("p2_drained1", WW'(exp_q1.size()), WW'(0));
    step();

    // req1 continuous with res1_ready low: credit stops at DEPTH grants
    res1_ready = 1'b0;
    g1 = 0;
    for (int i = 0; i < 12; i++) begin
      req1_valid = 1'b1;
      req1_data  = rand_pix();
      req1_count = 4'($urandom_range(1, 8));
      @(negedge clk);
      if (req1_ready) g1++;
      step();
    end
    check("p3_credit_grants", WW'(g1), WW'(DEPTH));
    req1_data  = rand_pix();
    res1_ready = 1'b1;
    @(negedge clk);
    check("p3_full_res1_valid", WW'(res1_valid), WW'(1'b1));
    check("p3_no_grant_on_pop", WW'(req1_ready), WW'(1'b0));
    step();
    res1_ready = 1'b0;
    req1_data  = rand_pix();
    @(negedge clk);
    check("p3_grant_after_pop", WW'(req1_ready), WW'(1'b1));
    step();
    req1_data = rand_pix();
    @(negedge clk);
    check("p3_blocked_again", WW'(req1_ready), WW'(1'b0));
    step();
    req1_valid = 1'b0;
    res1_ready = 1'b1;
    repeat (15) step();
    @(negedge clk);
    check("p3_drained1", WW'(exp_q1.size()), WW'(0));
    check("p3_cnt_err_clear", WW'(cnt_err), WW'(1'b0));
    step();

    // Out-of-range count: engine sees 0, flag sticks, result still returned
    req0_valid = 1'b1;
    req0_data  = rand_pix();
    req0_count = 4'd11;
    @(negedge clk);
    check("p4_ready0", WW'(req0_ready), WW'(1'b1));
    step();
    req0_valid = 1'b0;
    @(negedge clk);
    check("p4_med_valid_in", WW'(med_valid_in), WW'(1'b1));
    check("p4_med_count", WW'(med_count), WW'(0));
    check("p4_cnt_err", WW'(cnt_err), WW'(1'b1));
    repeat (10) step();
    @(negedge clk);
    check("p4_cnt_err_sticky", WW'(cnt_err), WW'(1'b1));
    check("p4_drained0", WW'(exp_q0.size()), WW'(0));
    check("p5_seq_err_before", WW'(seq_err), WW'(1'b0));

    // Spurious engine result with nothing in flight
    inject = 1'b1;
    step();
    @(negedge clk);
    inject = 1'b0;
    step();
    @(negedge clk);
    check("p5_seq_err", WW'(seq_err), WW'(1'b1));
    check("p5_res0_unchanged", WW'(res0_valid), WW'(1'b0));
    check("p5_res1_unchanged", WW'(res1_valid), WW'(1'b0));
    step();

    // Reset two cycles after three jobs; late results are dropped and flagged
    res0_ready = 1'b1;
    for (int j = 0; j < 3; j++) begin
      req0_valid = 1'b1;
      req0_data  = rand_pix();
      req0_count = 4'($urandom_range(1, 8));
      @(negedge clk);
      check("p6_ready0", WW'(req0_ready), WW'(1'b1));
      step();
    end
    req0_valid = 1'b0;
    step();
    rst = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
    step();
    @(negedge clk);
    check_all_zero("p6_reset");
    step();
    rst = 1'b0;
    step();
    @(negedge clk);
    check("p6_late_seq_err", WW'(seq_err), WW'(1'b1));
    check("p6_late_dropped", WW'(res0_valid), WW'(1'b0));
    step();
    step();
    req0_valid = 1'b1;
    req0_data  = rand_pix();
    req0_count = 4'($urandom_range(1, 8));
    @(negedge clk);
    check("p6_new_ready0", WW'(req0_ready), WW'(1'b1));
    step();
    req0_valid = 1'b0;
    lat   = 0;
    found = 1'b0;
    for (int k = 1; k <= 20 && !found; k++) begin
      @(negedge clk);
      if (res0_valid) begin
        found = 1'b1;
        lat   = k;
      end
      step();
    end
    check("p6_new_job_latency", WW'(lat), WW'(LAT + 2));

    // Random traffic against the reference model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      req0_valid = ($urandom_range(0, 99) < 60);
      req1_valid = ($urandom_range(0, 99) < 60);
      req0_data  = rand_pix();
      req1_data  = rand_pix();
      req0_count = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      req1_count = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      res0_ready = ($urandom_range(0, 99) < 50);
      res1_ready = ($urandom_range(0, 99) < 50);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    res0_ready = 1'b1;
    res1_ready = 1'b1;
    repeat (20) step();
    @(negedge clk);
    check("p7_drained0", WW'(exp_q0.size()), WW'(0));
    check("p7_drained1", WW'(exp_q1.size()), WW'(0));
    check("p7_seq_err", WW'(seq_err), WW'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/median_engine_arbiter.md
Name: median_engine_arbiter

Overview:
- Shares one fast median engine between two neighbour-median requesters, for example the dead-pixel detection path (req0) and the correction path (req1).
- Arbitrates round-robin and issues at most one job per cycle to the engine.
- Tracks which requester owns each in-flight job with a tag pipeline that matches the engine latency.
- Returns each median through a per-requester result FIFO with valid/ready handshake. Grants are credit-limited so a FIFO can never overflow.

Parameters:
- DATA_WIDTH, 16, pixel and median width.
- MED_LATENCY, 3, engine cycles from med_valid_in to med_valid_out; must be >= 1.
- FIFO_DEPTH, 4, result FIFO entries per requester; power of 2, >= 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  requester 0 has a job.
- req0_ready  out  1  job accepted this cycle.
- req0_data  in  8*DATA_WIDTH  neighbour pixels; slot k is bits [k*DATA_WIDTH +: DATA_WIDTH].
- req0_count  in  4  number of valid neighbours (0..8).
- req1_valid / req1_ready / req1_data / req1_count  same as req0, for requester 1.
- med_valid_in  out  1  job strobe to the engine.
- med_data  out  8*DATA_WIDTH  pixels to the engine.
- med_count  out  4  valid count to the engine.
- med_valid_out  in  1  engine result strobe.
- med_median  in  DATA_WIDTH  engine result.
- res0_valid  out  1  result available for requester 0.
- res0_ready  in  1  requester 0 consumes the result.
- res0_median  out  DATA_WIDTH  head-of-FIFO result for requester 0.
- res1_valid / res1_ready / res1_median  same as res0, for requester 1.
- cnt_err  out  1  sticky: a job arrived with count > 8.
- seq_err  out  1  sticky: engine result arrived with no matching tag, or a tag expired without a result.

Behaviour:
- Reset (rst=1 at a clk edge):
  - All outputs go to 0: reqX_ready, med_valid_in, med_data, med_count, resX_valid, resX_median, cnt_err, seq_err.
  - FIFOs are emptied, in-flight counters cleared, tag pipeline cleared, rr_last set to 1 so req0 wins first.
- Eligibility: elig_i = (fifo_cnt_i + inflight_i) < FIFO_DEPTH, using registered counts only. A pop in the same cycle gives no credit back until the next cycle.
- Grant (combinational):
  - If only one requester is valid and eligible, it is granted.
  - If both are, grant the one != rr_last.
  - reqX_ready = grant_X; at most one ready per cycle. ready may depend on valid.
- On handshake (valid & ready):
  - Register data to med_data and count to med_count; set med_valid_in=1 for exactly the next cycle.
  - Otherwise med_valid_in=0; med_data and med_count hold their previous values.
  - rr_last <= granted index; inflight_i += 1.
- Count > 8: forward med_count=0 and set cnt_err. The job still completes and returns the engine's result (0).
- Tag pipeline:
  - MED_LATENCY stages of {valid, id}, loaded in step with med_valid_in and shifted every cycle.
  - Stage-out valid and med_valid_out are both expected on the same cycle.
- Result capture:
  - When med_valid_out and the tag-out are valid together, push med_median into FIFO[id] and set inflight_id -= 1.
  - If exactly one of med_valid_out or tag-out valid is asserted: set seq_err; on a tag-only expiry also decrement that requester's inflight; drop any untagged result.
- FIFO:
  - resX_valid = !empty; resX_median = head entry (registered storage).
  - Pop on resX_valid & resX_ready; a pop while empty is ignored.
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - Overflow is impossible by the credit rule; it is asserted in simulation.
- Latency: handshake at cycle N gives med_valid_in at N+1, the engine result at N+1+MED_LATENCY, the FIFO write at that edge, and resX_valid at N+2+MED_LATENCY (5 cycles at default).
- Throughput: 1 job per cycle aggregate; a single requester can sustain 1 job per cycle while its credit lasts.
- Reset mid-operation: all in-flight tags are discarded. Engine results arriving after reset are untagged: dropped, and seq_err is set.
- Sticky flags clear only on rst.

Test Plan:
- Single job, req0, count=8, data 10,20,...,80; engine model returns 45 after 3 cycles -> req0_ready at cycle 0, med_valid_in at cycle 1, res0_valid=1 with res0_median=45 at cycle 5, res1_valid stays 0.
- Both requesters valid every cycle for 8 cycles, res ready held 1 -> grants alternate 0,1,0,1,...; each gets 4 jobs and results return in issue order per requester.
- req1 continuous with res1_ready=0 -> exactly 4 grants, then req1_ready=0. Raising res1_ready for 1 cycle gives one more grant 1 cycle later; no lost or duplicated results.
- req0_count=11 -> med_count=0, cnt_err=1 permanently, result still delivered to res0.
- Engine model injects a spurious med_valid_out with no job -> seq_err=1, both FIFOs unchanged.
- rst pulsed 2 cycles after issuing 3 jobs -> all outputs 0, FIFOs empty; late engine results dropped with seq_err=1; a new job after reset completes normally in 5 cycles.
